// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every domain reset for HOLD_CYCLES, then releases domains in index order GAP_CYCLES apart.
// Optional feature macro RESET_SEQ_COUNT_EN adds the seq_cnt completed-sequence counter output.
module reset_sequencer #(
    parameter int N_DOMAINS   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           cur_dom
`ifdef RESET_SEQ_COUNT_EN
    ,
    output logic [7:0]           seq_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2
    } state_t;

    // Counters hold (cycle number - 1), so the terminal values are one below the parameters.
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_DOM  = 4'(N_DOMAINS - 1);

    state_t                 state_r;
    logic [15:0]            cnt_r;
    logic [N_DOMAINS-1:0]   dom_rst_r;
    logic                   busy_r;
    logic                   done_r;
    logic [3:0]             cur_dom_r;

    // Sequencer FSM: restart on rst/req, hold phase, then one release per gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_HOLD;
            cnt_r     <= 16'd0;
            dom_rst_r <= {N_DOMAINS{1'b1}};
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            cur_dom_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            if (req) begin
                // A request always restarts, even on the cycle that would have completed.
                state_r   <= ST_HOLD;
                cnt_r     <= 16'd0;
                dom_rst_r <= {N_DOMAINS{1'b1}};
                busy_r    <= 1'b1;
                cur_dom_r <= 4'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= 16'd0;
                    end
                    ST_HOLD: begin
                        if (cnt_r == HOLD_LAST) begin
                            cnt_r <= 16'd0;
                            if (N_DOMAINS == 1) begin
                                state_r   <= ST_IDLE;
                                dom_rst_r <= {N_DOMAINS{1'b0}};
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                cur_dom_r <= 4'd0;
                            end else begin
                                state_r   <= ST_STAGGER;
                                dom_rst_r <= dom_rst_r << 1;
                                cur_dom_r <= 4'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    ST_STAGGER: begin
                        if (cnt_r == GAP_LAST) begin
                            cnt_r <= 16'd0;
                            if (cur_dom_r == LAST_DOM) begin
                                state_r   <= ST_IDLE;
                                dom_rst_r <= {N_DOMAINS{1'b0}};
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                cur_dom_r <= 4'd0;
                            end else begin
                                // Shifting zeros in from bit 0 keeps releases strictly index-ordered.
                                dom_rst_r <= dom_rst_r << 1;
                                cur_dom_r <= cur_dom_r + 4'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    default: begin
                        state_r   <= ST_HOLD;
                        cnt_r     <= 16'd0;
                        dom_rst_r <= {N_DOMAINS{1'b1}};
                        busy_r    <= 1'b1;
                        cur_dom_r <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign dom_rst = dom_rst_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign cur_dom = cur_dom_r;

`ifdef RESET_SEQ_COUNT_EN
    logic [7:0] seq_cnt_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Completed-sequence counter, bumped once per done pulse and saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt_r <= 8'd0;
        end else if (done_r) begin
            seq_cnt_r <= sat_inc8(seq_cnt_r);
        end else begin
            seq_cnt_r <= seq_cnt_r;
        end
    end

    assign seq_cnt = seq_cnt_r;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default build plus a single-domain, one-cycle-hold instance.
// The expected response of each clock edge is queued when stimulus is issued and checked at the following negedge.
module tb_reset_sequencer;

    localparam int NA = 4, HA = 16, GA = 4;
    localparam int NB = 1, HB = 1,  GB = 1;

    typedef struct {
        logic [15:0] dom;
        logic        busy;
        logic        done;
        logic [3:0]  cur;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;

    logic [NA-1:0] dom_a;
    logic          busy_a, done_a;
    logic [3:0]    cur_a;
    logic [NB-1:0] dom_b;
    logic          busy_b, done_b;
    logic [3:0]    cur_b;
`ifdef RESET_SEQ_COUNT_EN
    logic [7:0]    seq_a, seq_b;
`endif

    reset_sequencer #(.N_DOMAINS(NA), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .dom_rst(dom_a), .busy(busy_a), .done(done_a), .cur_dom(cur_a)
`ifdef RESET_SEQ_COUNT_EN
        , .seq_cnt(seq_a)
`endif
    );

    reset_sequencer #(.N_DOMAINS(NB), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .dom_rst(dom_b), .busy(busy_b), .done(done_b), .cur_dom(cur_b)
`ifdef RESET_SEQ_COUNT_EN
        , .seq_cnt(seq_b)
`endif
    );

    always #5 clk = ~clk;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_obs_a = 0, done_exp_a = 0;

    // Reference model state: edges since the sequence (re)started, and whether one is in progress.
    int  pos_a = 0, pos_b = 0;
    bit  act_a = 1'b0, act_b = 1'b0;
    bit  pdone_a = 1'b0, pdone_b = 1'b0;
    int  sc_a = 0, sc_b = 0;

    task automatic model(input int n, input int h, input int g, input bit r, input bit q,
                         inout int pos, inout bit act, inout bit pdone, inout int sc,
                         output exp_t x);
        int rel;
        int total;
        logic [31:0] m;
        total = h + (n - 1) * g;
        if (r) sc = 0;
        else if (pdone && sc < 255) sc = sc + 1;
        if (r || q) begin
            pos = 0;
            act = 1'b1;
        end else if (act) begin
            pos = pos + 1;
        end
        if (act) begin
            rel = (pos < h) ? 0 : 1 + (pos - h) / g;
            if (rel > n) rel = n;
            m = 32'hFFFF_FFFF << rel;
            x.dom  = m[15:0] & 16'((32'd1 << n) - 32'd1);
            x.busy = (rel < n);
            x.done = (pos == total);
            x.cur  = (rel < n) ? 4'(rel) : 4'd0;
            if (rel == n) act = 1'b0;
        end else begin
            x.dom  = 16'd0;
            x.busy = 1'b0;
            x.done = 1'b0;
            x.cur  = 4'd0;
        end
        pdone = x.done;
        x.cnt = 8'(sc);
    endtask

    // Issue one edge's worth of stimulus and queue what both instances should show after it.
    task automatic step(input bit r, input bit q);
        exp_t xa, xb;
        rst = r;
        req = q;
        model(NA, HA, GA, r, q, pos_a, act_a, pdone_a, sc_a, xa);
        model(NB, HB, GB, r, q, pos_b, act_b, pdone_b, sc_b, xb);
        if (xa.done) done_exp_a++;
        qa.push_back(xa);
        qb.push_back(xb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: pop the expectation for the most recent edge and compare both instances.
    always @(negedge clk) begin
        exp_t ea, eb;
        cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            if (done_a) done_obs_a++;
            chk("a_dom_rst", int'(dom_a), int'(ea.dom));
            chk("a_busy",    int'(busy_a), int'(ea.busy));
            chk("a_done",    int'(done_a), int'(ea.done));
            chk("a_cur_dom", int'(cur_a), int'(ea.cur));
`ifdef RESET_SEQ_COUNT_EN
            chk("a_seq_cnt", int'(seq_a), int'(ea.cnt));
`endif
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_dom_rst", int'(dom_b), int'(eb.dom));
            chk("b_busy",    int'(busy_b), int'(eb.busy));
            chk("b_done",    int'(done_b), int'(eb.done));
            chk("b_cur_dom", int'(cur_b), int'(eb.cur));
`ifdef RESET_SEQ_COUNT_EN
            chk("b_seq_cnt", int'(seq_b), int'(eb.cnt));
`endif
        end
    end

    initial begin
        int burst;
        bit r, q;
        // Power-on: reset for 3 edges, then a full sequence without any request.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(35);
        // Single-cycle request from idle.
        step(1'b0, 1'b1);
        idle(35);
        // Restart two cycles after dom_rst reaches 1100.
        step(1'b0, 1'b1);
        idle(HA + GA + 1);
        step(1'b0, 1'b1);
        idle(35);
        // Request coincident with the final release edge.
        step(1'b0, 1'b1);
        idle(HA + (NA - 1) * GA - 1);
        step(1'b0, 1'b1);
        idle(35);
        // Request held high, then released.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        idle(35);
        // Reset in the middle of the stagger phase.
        step(1'b0, 1'b1);
        idle(HA + 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(35);
        // Randomized requests, held bursts and occasional resets.
        burst = 0;
        for (int i = 0; i < 1200; i++) begin
            r = ($urandom_range(0, 149) == 0);
            if (burst > 0) begin
                q = 1'b1;
                burst--;
            end else begin
                q = ($urandom_range(0, 39) == 0);
                if (q && $urandom_range(0, 3) == 0) burst = int'($urandom_range(2, 25));
            end
            step(r, q);
        end
        idle(35);
`ifdef RESET_SEQ_COUNT_EN
        // Enough completed sequences to saturate the counters.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1);
            idle(30);
        end
`endif
        @(negedge clk);
        #1;
        chk("done_pulse_count", done_obs_a, done_exp_a);
        chk("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_DOMAINS, default 4: number of sequenced reset domains, legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all domain resets stay asserted before the first release, legal range 1..65535.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between consecutive domain releases, legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high block reset.
REQ-006 req  input  1  sequence request, sampled each cycle; level or pulse accepted.
REQ-007 dom_rst  output  N_DOMAINS  per-domain reset, active-high, registered; feeds the rst pins of domain async-reset registers.
REQ-008 busy  output  1  high while any dom_rst bit is asserted.
REQ-009 done  output  1  single-cycle pulse marking sequence completion.
REQ-010 cur_dom  output  4  index of the next domain to release, registered.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, HOLD and STAGGER.
REQ-012 HOLD: all dom_rst bits = 1; a 16-bit counter counts cycles from 1.
  - Cycle HOLD_CYCLES: the next edge clears dom_rst[0], sets cur_dom=1 and enters STAGGER with the counter at 0.
REQ-013 STAGGER: the counter counts from 1.
  - Cycle GAP_CYCLES: the next edge clears dom_rst[cur_dom] and increments cur_dom.
  - The counter then restarts.
REQ-014 Releases SHALL be strictly ordered by index: dom_rst[i] falls exactly GAP_CYCLES cycles after dom_rst[i-1]; at no time is dom_rst[i]=0 while dom_rst[i-1]=1.
REQ-015 On the edge that clears dom_rst[N_DOMAINS-1], the FSM SHALL:
  - enter IDLE;
  - drive busy to 0 and done to 1 for exactly one cycle;
  - reset cur_dom to 0.
REQ-016 If N_DOMAINS=1, STAGGER SHALL be skipped; the end of HOLD performs the REQ-015 actions directly.
REQ-017 IDLE with req=1: the next edge SHALL assert all dom_rst bits, set busy=1, clear cur_dom and the counter, and enter HOLD.
REQ-018 req=1 in HOLD or STAGGER SHALL restart the sequence on the next edge: all dom_rst re-asserted, HOLD counter from 1, cur_dom=0, no done pulse.
REQ-019 req=1 on the cycle that would complete the sequence: the restart SHALL win; done stays 0 and busy stays 1.
REQ-020 req held high continuously SHALL keep the block in HOLD at count 1; the sequence proceeds only after req falls.
REQ-021 Counters SHALL never wrap; all comparisons use full 16-bit width.

Reset
REQ-022 While rst=1, on each edge:
  - dom_rst = all ones, busy = 1, done = 0, cur_dom = 0;
  - state = HOLD with the counter at 0.
REQ-023 The first cycle after rst falls SHALL be HOLD cycle 1, so power-on produces a full sequence without req.
REQ-024 rst asserted mid-sequence SHALL behave identically to REQ-022, with no done pulse.

Configuration
REQ-025 Macro RESET_SEQ_COUNT_EN:
  - Defined: adds output seq_cnt (8 bits), cleared by rst, incremented on every done pulse, saturating at 255.
  - Undefined: the port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-026 Defaults, rst high 3 cycles then low, req=0 -> dom_rst=4'b1111 for 16 cycles, then falls to 1110, 1100, 1000, 0000 at 4-cycle intervals. done pulses once, coincident with 0000; busy falls on the same edge.
REQ-027 From IDLE, 1-cycle req pulse -> the next cycle shows dom_rst=1111, busy=1; the release timing matches REQ-026 measured from that cycle.
REQ-028 req pulse 2 cycles after dom_rst reaches 1100 -> the next cycle shows 1111, the full 16-cycle hold repeats, and only one done pulse occurs overall.
REQ-029 req coincident with the final release cycle -> dom_rst returns to 1111, done never pulses, busy stays 1.
REQ-030 N_DOMAINS=1, HOLD_CYCLES=1 -> dom_rst falls 1 cycle after rst deasserts, with done pulsing on the same edge. With RESET_SEQ_COUNT_EN, 300 sequences -> seq_cnt=255.
